// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg
// Shared definitions for the iterative multiply/divide sequencer:
//   - op encoding driven by the control FSM on 'op'
//   - sequencer state encoding
//   - number of shift/add or shift/subtract iterations per operation
package muldiv_seq_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // One iteration per operand bit; must equal the datapath WIDTH.
  localparam int ITER = 32;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
    DONE,
    DZ
  } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if
// Request/result bundle between the main control FSM (master) and the
// multiply/divide sequencer (slave).
//   start, op, a, b         : request from the control FSM
//   busy, done, div_zero    : status back to the control FSM / exception logic
//   hi_out, lo_out          : values for the HI and LO registers
//   hi_we, lo_we            : HI/LO write enables (always asserted together)
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             hi_we;
  logic             lo_we;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi_out, lo_out, hi_we, lo_we
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi_out, lo_out, hi_we, lo_we
  );

endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Iterative signed multiply / restoring divide for the HI/LO registers.
// An accepted request runs ITER CALC cycles on operand magnitudes, one FIX
// cycle that applies result signs, then one DONE cycle that pulses the
// write enables. Division by zero takes a single DZ cycle instead.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : muldiv_seq_if slave (start/op/a/b in; busy/done/div_zero,
//           hi_out/lo_out, hi_we/lo_we out)
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  muldiv_seq_if.slave bus
);

  localparam int CNT_W = $clog2(ITER);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  // Shared shift register.
  //   mult: {partial product high half, remaining multiplier bits}
  //   div : {partial remainder, remaining dividend bits / quotient bits}
  logic [2*WIDTH-1:0] r_acc;
  // Multiplicand magnitude (mult) or divisor magnitude (div).
  logic [WIDTH-1:0]   r_opnd;
  logic               r_op;
  logic               r_neg_res;  // product / quotient must be negated
  logic               r_neg_rem;  // remainder takes the dividend's sign
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_prod_fix;

  // Magnitudes as unsigned values; the most negative input maps onto
  // itself, which is its correct unsigned magnitude.
  assign w_mag_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_mag_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

  // Multiply step: conditionally add the multiplicand into the high half;
  // the carry lands in bit WIDTH and is shifted down with everything else.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // Divide step: remainder shifted left with the next dividend bit, minus
  // the divisor. Bit WIDTH set means the trial went negative (restore).
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};

  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.div_zero = 1'b0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_state_next = (bus.op == OP_DIV && bus.b == '0) ? DZ : CALC;
        end
      end
      CALC: begin
        if (r_cnt == CNT_W'(ITER - 1)) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
        bus.done     = 1'b1;
        bus.hi_we    = 1'b1;
        bus.lo_we    = 1'b1;
      end
      DZ: begin
        w_state_next = IDLE;
        bus.div_zero = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_op      <= OP_MULT;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Capture also happens on a DZ request; the values are never
          // used because DZ returns straight to IDLE.
          if (bus.start) begin
            r_cnt     <= '0;
            r_op      <= bus.op;
            r_neg_res <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_neg_rem <= bus.a[WIDTH-1];
            if (bus.op == OP_DIV) begin
              r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
              r_opnd <= w_mag_b;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
              r_opnd <= w_mag_a;
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op == OP_DIV) begin
            if (w_trial[WIDTH]) begin
              r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
            end else begin
              r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (r_op == OP_DIV) begin
            r_lo <= r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            r_hi <= r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
          end else begin
            r_lo <= w_prod_fix[WIDTH-1:0];
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
// Self-checking bench for muldiv_seq. Each operation is launched by do_op,
// which records per-cycle observations; the test tasks compare those
// against a plain-arithmetic reference (64-bit signed multiply / divide).
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int RUN_CYC = 75;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic        obs_busy [0:RUN_CYC];
  logic [31:0] obs_hi   [0:RUN_CYC];
  logic [31:0] obs_lo   [0:RUN_CYC];
  int obs_busy_cnt, obs_done_cnt, obs_first_done, obs_last_done;
  int obs_we_cnt, obs_we_bad, obs_dz_cnt, obs_first_dz;

  function automatic logic [63:0] ref_model(input logic op_i,
                                            input logic [31:0] a_i,
                                            input logic [31:0] b_i);
    longint sa, sb, q, r;
    logic [63:0] pv, qv, rv;
    sa = longint'($signed(a_i));
    sb = longint'($signed(b_i));
    if (op_i == OP_MULT) begin
      pv = sa * sb;
      return pv;
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Launch one request at edge E0 and watch cycles 1..RUN_CYC. Optional
  // extra start pulses (rp1/rp2) and a reset cycle (rst_cyc, 0 = together
  // with the request) can be injected; -1 disables them.
  task automatic do_op(input logic op_i, input logic [31:0] a_i,
                       input logic [31:0] b_i, input int rp1, input int rp2,
                       input logic rp_op, input logic [31:0] rp_a,
                       input logic [31:0] rp_b, input int rst_cyc);
    obs_busy_cnt = 0; obs_done_cnt = 0; obs_first_done = 0; obs_last_done = 0;
    obs_we_cnt = 0; obs_we_bad = 0; obs_dz_cnt = 0; obs_first_dz = 0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    reset     = (rst_cyc == 0);
    @(posedge clock);
    #1;
    for (int cyc = 1; cyc <= RUN_CYC; cyc++) begin
      obs_busy[cyc] = bus.busy;
      obs_hi[cyc]   = bus.hi_out;
      obs_lo[cyc]   = bus.lo_out;
      if (bus.busy) obs_busy_cnt++;
      if (bus.done) begin
        obs_done_cnt++;
        if (obs_first_done == 0) obs_first_done = cyc;
        obs_last_done = cyc;
      end
      if (bus.hi_we || bus.lo_we) obs_we_cnt++;
      if (bus.hi_we !== bus.done || bus.lo_we !== bus.done) obs_we_bad++;
      if (bus.div_zero) begin
        obs_dz_cnt++;
        if (obs_first_dz == 0) obs_first_dz = cyc;
      end
      if (cyc == rp1 || cyc == rp2) begin
        bus.start = 1'b1;
        bus.op    = rp_op;
        bus.a     = rp_a;
        bus.b     = rp_b;
      end else begin
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      reset = (cyc == rst_cyc);
      @(posedge clock);
      #1;
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    $display("txn op=%0d a=%h b=%h dones=%0d first_done=%0d hi=%h lo=%h",
             op_i, a_i, b_i, obs_done_cnt, obs_first_done,
             obs_hi[RUN_CYC], obs_lo[RUN_CYC]);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if ({bus.done, bus.div_zero, bus.hi_we, bus.lo_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=0000",
               {bus.done, bus.div_zero, bus.hi_we, bus.lo_we});
    end
    checks++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_hilo got=%h_%h exp=0_0", bus.hi_out, bus.lo_out);
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    $display("txn reset busy=%b hi=%h lo=%h", bus.busy, bus.hi_out, bus.lo_out);
  endtask

  // Common per-result checks are written out in each test on purpose.
  task automatic test_mult();
    logic [31:0] ta [0:3];
    logic [31:0] tb [0:3];
    logic [31:0] a_v, b_v;
    logic [63:0] exp;
    ta[0] = 32'd7;        tb[0] = 32'hFFFFFFFD;
    ta[1] = 32'h80000000; tb[1] = 32'h80000000;
    ta[2] = 32'd5;        tb[2] = 32'd0;
    ta[3] = 32'hFFFFFFFF; tb[3] = 32'h7FFFFFFF;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        a_v = ta[i];
        b_v = tb[i];
      end else begin
        a_v = $urandom;
        b_v = $urandom;
      end
      exp = ref_model(OP_MULT, a_v, b_v);
      do_op(OP_MULT, a_v, b_v, -1, -1, OP_MULT, 32'h0, 32'h0, -1);
      checks++;
      if (obs_done_cnt !== 1 || obs_first_done !== 34) begin
        failures++;
        $display("FAIL mult_done_timing a=%h b=%h got_cnt=%0d got_cyc=%0d exp_cnt=1 exp_cyc=34",
                 a_v, b_v, obs_done_cnt, obs_first_done);
      end
      checks++;
      if (obs_busy_cnt !== 34 || obs_busy[1] !== 1'b1 || obs_busy[34] !== 1'b1 ||
          obs_busy[35] !== 1'b0) begin
        failures++;
        $display("FAIL mult_busy_window got_cnt=%0d b1=%b b34=%b b35=%b exp=34/1/1/0",
                 obs_busy_cnt, obs_busy[1], obs_busy[34], obs_busy[35]);
      end
      checks++;
      if (obs_we_cnt !== 1 || obs_we_bad !== 0) begin
        failures++;
        $display("FAIL mult_we got_cnt=%0d got_mismatch=%0d exp=1/0", obs_we_cnt, obs_we_bad);
      end
      checks++;
      if ({obs_hi[34], obs_lo[34]} !== exp) begin
        failures++;
        $display("FAIL mult_result a=%h b=%h got=%h_%h exp=%h_%h",
                 a_v, b_v, obs_hi[34], obs_lo[34], exp[63:32], exp[31:0]);
      end
      checks++;
      if ({obs_hi[RUN_CYC], obs_lo[RUN_CYC]} !== exp || obs_dz_cnt !== 0) begin
        failures++;
        $display("FAIL mult_hold got=%h_%h dz=%0d exp=%h_%h dz=0",
                 obs_hi[RUN_CYC], obs_lo[RUN_CYC], obs_dz_cnt, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] ta [0:3];
    logic [31:0] tb [0:3];
    logic [31:0] a_v, b_v;
    logic [63:0] exp;
    ta[0] = 32'hFFFFFFF9; tb[0] = 32'd2;
    ta[1] = 32'h80000000; tb[1] = 32'hFFFFFFFF;
    ta[2] = 32'd3;        tb[2] = 32'hFFFFFFF9;
    ta[3] = 32'h80000000; tb[3] = 32'd1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        a_v = ta[i];
        b_v = tb[i];
      end else begin
        a_v = $urandom;
        b_v = (i % 2 == 0) ? $urandom : $urandom_range(1, 40);
        if (i % 3 == 0) b_v = -b_v;
        if (b_v == 32'h0) b_v = 32'd1;
      end
      exp = ref_model(OP_DIV, a_v, b_v);
      do_op(OP_DIV, a_v, b_v, -1, -1, OP_MULT, 32'h0, 32'h0, -1);
      checks++;
      if (obs_done_cnt !== 1 || obs_first_done !== 34) begin
        failures++;
        $display("FAIL div_done_timing a=%h b=%h got_cnt=%0d got_cyc=%0d exp_cnt=1 exp_cyc=34",
                 a_v, b_v, obs_done_cnt, obs_first_done);
      end
      checks++;
      if (obs_busy_cnt !== 34 || obs_busy[34] !== 1'b1 || obs_busy[35] !== 1'b0) begin
        failures++;
        $display("FAIL div_busy_window got_cnt=%0d b34=%b b35=%b exp=34/1/0",
                 obs_busy_cnt, obs_busy[34], obs_busy[35]);
      end
      checks++;
      if (obs_we_cnt !== 1 || obs_we_bad !== 0 || obs_dz_cnt !== 0) begin
        failures++;
        $display("FAIL div_we got_cnt=%0d got_mismatch=%0d got_dz=%0d exp=1/0/0",
                 obs_we_cnt, obs_we_bad, obs_dz_cnt);
      end
      checks++;
      if ({obs_hi[34], obs_lo[34]} !== exp) begin
        failures++;
        $display("FAIL div_result a=%h b=%h got_rem=%h got_quo=%h exp_rem=%h exp_quo=%h",
                 a_v, b_v, obs_hi[34], obs_lo[34], exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] prev;
    prev = ref_model(OP_MULT, 32'h00012345, 32'hFFFF6789);
    do_op(OP_MULT, 32'h00012345, 32'hFFFF6789, -1, -1, OP_MULT, 32'h0, 32'h0, -1);
    do_op(OP_DIV, 32'd5, 32'd0, -1, -1, OP_MULT, 32'h0, 32'h0, -1);
    checks++;
    if (obs_dz_cnt !== 1 || obs_first_dz !== 1) begin
      failures++;
      $display("FAIL dz_pulse got_cnt=%0d got_cyc=%0d exp=1/1", obs_dz_cnt, obs_first_dz);
    end
    checks++;
    if (obs_busy_cnt !== 1 || obs_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL dz_busy got_cnt=%0d b1=%b exp=1/1", obs_busy_cnt, obs_busy[1]);
    end
    checks++;
    if (obs_done_cnt !== 0 || obs_we_cnt !== 0) begin
      failures++;
      $display("FAIL dz_no_write got_done=%0d got_we=%0d exp=0/0", obs_done_cnt, obs_we_cnt);
    end
    checks++;
    if ({obs_hi[2], obs_lo[2]} !== prev || {obs_hi[RUN_CYC], obs_lo[RUN_CYC]} !== prev) begin
      failures++;
      $display("FAIL dz_hilo_kept got=%h_%h exp=%h_%h",
               obs_hi[RUN_CYC], obs_lo[RUN_CYC], prev[63:32], prev[31:0]);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] exp;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom | 32'h1;
    exp = ref_model(OP_MULT, a1, b1);
    do_op(OP_MULT, a1, b1, 10, 34, OP_DIV, a2, b2, -1);
    checks++;
    if (obs_done_cnt !== 1 || obs_first_done !== 34 || {obs_hi[34], obs_lo[34]} !== exp) begin
      failures++;
      $display("FAIL ignore_start_result got_cnt=%0d got=%h_%h exp_cnt=1 exp=%h_%h",
               obs_done_cnt, obs_hi[34], obs_lo[34], exp[63:32], exp[31:0]);
    end
    checks++;
    if (obs_busy_cnt !== 34 || obs_busy[35] !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_busy got_cnt=%0d b35=%b exp=34/0", obs_busy_cnt, obs_busy[35]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] exp1, exp2;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    exp1 = ref_model(OP_MULT, a1, b1);
    exp2 = ref_model(OP_DIV, a2, b2);
    do_op(OP_MULT, a1, b1, 35, -1, OP_DIV, a2, b2, -1);
    checks++;
    if (obs_busy[35] !== 1'b0 || obs_busy[36] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept b35=%b b36=%b exp=0/1", obs_busy[35], obs_busy[36]);
    end
    checks++;
    if (obs_done_cnt !== 2 || obs_first_done !== 34 || obs_last_done !== 69) begin
      failures++;
      $display("FAIL b2b_done got_cnt=%0d first=%0d last=%0d exp=2/34/69",
               obs_done_cnt, obs_first_done, obs_last_done);
    end
    checks++;
    if ({obs_hi[34], obs_lo[34]} !== exp1 || {obs_hi[69], obs_lo[69]} !== exp2) begin
      failures++;
      $display("FAIL b2b_results got=%h_%h,%h_%h exp=%h_%h,%h_%h",
               obs_hi[34], obs_lo[34], obs_hi[69], obs_lo[69],
               exp1[63:32], exp1[31:0], exp2[63:32], exp2[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    do_op(OP_MULT, $urandom | 32'h1, $urandom | 32'h1, -1, -1, OP_MULT, 32'h0, 32'h0, 10);
    checks++;
    if (obs_busy[10] !== 1'b1 || obs_busy[11] !== 1'b0 || obs_busy_cnt !== 10) begin
      failures++;
      $display("FAIL reset_mid_busy b10=%b b11=%b cnt=%0d exp=1/0/10",
               obs_busy[10], obs_busy[11], obs_busy_cnt);
    end
    checks++;
    if (obs_hi[11] !== 32'h0 || obs_lo[11] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_hilo got=%h_%h exp=0_0", obs_hi[11], obs_lo[11]);
    end
    checks++;
    if (obs_we_cnt !== 0 || obs_done_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_write got_we=%0d got_done=%0d exp=0/0", obs_we_cnt, obs_done_cnt);
    end
    // Reset and start on the same edge: reset wins.
    do_op(OP_MULT, 32'd9, 32'd9, -1, -1, OP_MULT, 32'h0, 32'h0, 0);
    checks++;
    if (obs_busy_cnt !== 0 || obs_done_cnt !== 0 || obs_we_cnt !== 0) begin
      failures++;
      $display("FAIL reset_over_start got_busy=%0d got_done=%0d got_we=%0d exp=0/0/0",
               obs_busy_cnt, obs_done_cnt, obs_we_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
